// File: rtl/tablero_buscaminas.sv
// Minesweeper board controller: places mines from a free-running LFSR, moves a
// cursor, reveals/flags cells and counts the mines around each safe reveal.
module tablero_buscaminas #(
  parameter int          BOMBS     = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_game,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_reveal,
  input  logic        btn_flag,
  output logic        bomb,
  output logic        win,
  output logic        play,
  output logic        ready,
  output logic [2:0]  cursor_x,
  output logic [2:0]  cursor_y,
  output logic [63:0] revealed_map,
  output logic [63:0] flag_map,
  output logic [63:0] bomb_map,
  output logic [3:0]  adj_count,
  output logic        adj_valid,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLACE = 3'd1,
    S_PLAY  = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [15:0] lfsr;
  logic [6:0]  placed;
  logic [6:0]  safe_cnt;
  logic [3:0]  scan;
  logic [3:0]  acc;

  logic [5:0]  cur_idx;
  logic        reveal_ok;
  logic        last_safe;
  logic        place_new;
  logic        place_done;
  logic [3:0]  dx, dy, nx, ny;
  logic        nb_mine;

  assign cur_idx    = {cursor_y, cursor_x};
  assign reveal_ok  = btn_reveal && !revealed_map[cur_idx] && !flag_map[cur_idx];
  assign last_safe  = (safe_cnt + 7'd1) == 7'(64 - BOMBS);
  assign place_new  = !bomb_map[lfsr[5:0]];
  assign place_done = place_new && ((placed + 7'd1) == 7'(BOMBS));
  assign ready      = (state == S_PLAY);
  assign state_dbg  = state;

  // Neighbour offsets in scan order NW, N, NE, W, E, SW, S, SE; 4'hF is -1.
  // A coordinate that leaves 0..7 sets bit 3, which marks the cell off-board.
  always_comb begin
    dx = 4'h0;
    dy = 4'h0;
    case (scan[2:0])
      3'd0: begin dx = 4'hF; dy = 4'hF; end
      3'd1: begin dx = 4'h0; dy = 4'hF; end
      3'd2: begin dx = 4'h1; dy = 4'hF; end
      3'd3: begin dx = 4'hF; dy = 4'h0; end
      3'd4: begin dx = 4'h1; dy = 4'h0; end
      3'd5: begin dx = 4'hF; dy = 4'h1; end
      3'd6: begin dx = 4'h0; dy = 4'h1; end
      default: begin dx = 4'h1; dy = 4'h1; end
    endcase
    nx      = {1'b0, cursor_x} + dx;
    ny      = {1'b0, cursor_y} + dy;
    nb_mine = !nx[3] && !ny[3] && bomb_map[{ny[2:0], nx[2:0]}];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_game) state_nx = S_PLACE;
      S_PLACE: begin
        if (!start_game)     state_nx = S_IDLE;
        else if (place_done) state_nx = S_PLAY;
      end
      S_PLAY: begin
        if (!start_game) state_nx = S_IDLE;
        else if (reveal_ok)
          state_nx = (bomb_map[cur_idx] || last_safe) ? S_DONE : S_COUNT;
      end
      S_COUNT: begin
        if (!start_game)       state_nx = S_IDLE;
        else if (scan == 4'd8) state_nx = S_PLAY;
      end
      S_DONE:  if (!start_game) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lfsr         <= LFSR_SEED;
      placed       <= '0;
      safe_cnt     <= '0;
      scan         <= '0;
      acc          <= '0;
      cursor_x     <= '0;
      cursor_y     <= '0;
      revealed_map <= '0;
      flag_map     <= '0;
      bomb_map     <= '0;
      adj_count    <= '0;
      adj_valid    <= 1'b0;
      bomb         <= 1'b0;
      win          <= 1'b0;
      play         <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      state     <= state_nx;
      play      <= 1'b0;
      bomb      <= 1'b0;
      win       <= 1'b0;
      adj_valid <= 1'b0;
      case (state)
        S_IDLE: if (start_game) begin
          revealed_map <= '0;
          flag_map     <= '0;
          bomb_map     <= '0;
          adj_count    <= '0;
          placed       <= '0;
          safe_cnt     <= '0;
          cursor_x     <= '0;
          cursor_y     <= '0;
        end
        S_PLACE: if (start_game && place_new) begin
          bomb_map[lfsr[5:0]] <= 1'b1;
          placed              <= placed + 7'd1;
        end
        // A reveal press owns the cycle even when the cell rejects it.
        S_PLAY: if (start_game) begin
          if (btn_reveal) begin
            if (reveal_ok) begin
              revealed_map[cur_idx] <= 1'b1;
              play                  <= 1'b1;
              if (bomb_map[cur_idx]) begin
                bomb         <= 1'b1;
                revealed_map <= revealed_map | bomb_map;
              end else if (last_safe) begin
                win <= 1'b1;
              end else begin
                safe_cnt <= safe_cnt + 7'd1;
                scan     <= '0;
                acc      <= '0;
              end
            end
          end else if (btn_flag) begin
            if (!revealed_map[cur_idx]) flag_map[cur_idx] <= !flag_map[cur_idx];
          end else if (btn_up) begin
            if (cursor_y != 3'd0) cursor_y <= cursor_y - 3'd1;
          end else if (btn_down) begin
            if (cursor_y != 3'd7) cursor_y <= cursor_y + 3'd1;
          end else if (btn_left) begin
            if (cursor_x != 3'd0) cursor_x <= cursor_x - 3'd1;
          end else if (btn_right) begin
            if (cursor_x != 3'd7) cursor_x <= cursor_x + 3'd1;
          end
        end
        S_COUNT: if (start_game) begin
          if (scan == 4'd8) begin
            adj_count <= acc;
            adj_valid <= 1'b1;
          end else begin
            acc  <= acc + {3'b000, nb_mine};
            scan <= scan + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tablero_buscaminas.sv
// Bench for tablero_buscaminas: a 10-mine and a 63-mine instance driven with
// random cursor traffic and reveals, checked against a plain board model.
module tb_tablero_buscaminas;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic btn_up, btn_down, btn_left, btn_right, btn_reveal, btn_flag;

  logic        a_bomb, a_win, a_play, a_ready, a_adjv;
  logic [2:0]  a_cx, a_cy, a_st;
  logic [63:0] a_rev, a_flag, a_bmap;
  logic [3:0]  a_adj;
  logic        b_bomb, b_win, b_play, b_ready, b_adjv;
  logic [2:0]  b_cx, b_cy, b_st;
  logic [63:0] b_rev, b_flag, b_bmap;
  logic [3:0]  b_adj;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  tablero_buscaminas #(.BOMBS(10)) u_dut_a (
    .clk(clk), .rst(rst), .start_game(start_a),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_reveal(btn_reveal), .btn_flag(btn_flag),
    .bomb(a_bomb), .win(a_win), .play(a_play), .ready(a_ready),
    .cursor_x(a_cx), .cursor_y(a_cy), .revealed_map(a_rev),
    .flag_map(a_flag), .bomb_map(a_bmap), .adj_count(a_adj),
    .adj_valid(a_adjv), .state_dbg(a_st)
  );

  tablero_buscaminas #(.BOMBS(63)) u_dut_b (
    .clk(clk), .rst(rst), .start_game(start_b),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_reveal(btn_reveal), .btn_flag(btn_flag),
    .bomb(b_bomb), .win(b_win), .play(b_play), .ready(b_ready),
    .cursor_x(b_cx), .cursor_y(b_cy), .revealed_map(b_rev),
    .flag_map(b_flag), .bomb_map(b_bmap), .adj_count(b_adj),
    .adj_valid(b_adjv), .state_dbg(b_st)
  );

  // Selected instance under test.
  logic        use_b;
  logic        c_bomb, c_win, c_play, c_ready, c_adjv;
  logic [2:0]  c_cx, c_cy;
  logic [63:0] c_rev, c_flag, c_bmap;
  logic [3:0]  c_adj;
  always_comb begin
    c_bomb = use_b ? b_bomb : a_bomb;
    c_win  = use_b ? b_win  : a_win;
    c_play = use_b ? b_play : a_play;
    c_ready = use_b ? b_ready : a_ready;
    c_adjv = use_b ? b_adjv : a_adjv;
    c_cx   = use_b ? b_cx   : a_cx;
    c_cy   = use_b ? b_cy   : a_cy;
    c_rev  = use_b ? b_rev  : a_rev;
    c_flag = use_b ? b_flag : a_flag;
    c_bmap = use_b ? b_bmap : a_bmap;
    c_adj  = use_b ? b_adj  : a_adj;
  end

  // ---------------- model + scoreboard ----------------
  int          n_pass   = 0;
  int          n_checks = 0;
  logic [2:0]  exp_q[$];           // expected {play,bomb,win} per reveal
  logic [63:0] m_bombs, m_rev, m_flag;
  int          m_x, m_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int adj_model(input int x, input int y);
    int c = 0;
    for (int ddy = -1; ddy <= 1; ddy++)
      for (int ddx = -1; ddx <= 1; ddx++)
        if (!(ddx == 0 && ddy == 0) && x + ddx >= 0 && x + ddx < 8 &&
            y + ddy >= 0 && y + ddy < 8 && m_bombs[(y + ddy) * 8 + x + ddx])
          c++;
    return c;
  endfunction

  function automatic logic [63:0] cur_model();
    return 64'((m_y * 8) + m_x);
  endfunction

  // ---------------- drivers ----------------
  // m = {reveal, flag, up, down, left, right}; held for exactly one edge.
  task automatic press(input logic [5:0] m);
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = m;
    @(negedge clk);
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 6'b0;
  endtask

  task automatic move(input logic [3:0] mv);
    press({2'b00, mv});
    if (mv[3])      m_y = (m_y > 0) ? m_y - 1 : 0;
    else if (mv[2]) m_y = (m_y < 7) ? m_y + 1 : 7;
    else if (mv[1]) m_x = (m_x > 0) ? m_x - 1 : 0;
    else if (mv[0]) m_x = (m_x < 7) ? m_x + 1 : 7;
    chk("cursor", 64'({c_cy, c_cx}), cur_model());
  endtask

  task automatic goto_cell(input int tx, input int ty);
    while (m_x < tx) move(4'b0001);
    while (m_x > tx) move(4'b0010);
    while (m_y < ty) move(4'b0100);
    while (m_y > ty) move(4'b1000);
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int i = 0;
    while (!c_ready && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 64'(c_ready), 64'(1));
  endtask

  task automatic reveal_safe(input int x, input int y, input bit with_flag);
    logic [2:0] e;
    int seen_adj, seen_play;
    goto_cell(x, y);
    exp_q.push_back(3'b100);
    press(with_flag ? 6'b110000 : 6'b100000);
    m_rev[y * 8 + x] = 1'b1;
    e = exp_q.pop_front();
    chk("reveal_pulses", 64'({c_play, c_bomb, c_win}), 64'(e));
    chk("revealed_map", c_rev, m_rev);
    chk("flag_dropped", c_flag, m_flag);
    seen_adj = 0;
    seen_play = 0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) btn_right = 1'b1;
      @(negedge clk);
      btn_right = 1'b0;
      seen_adj += int'(c_adjv);
      seen_play += int'(c_play);
    end
    chk("adj_early", 64'(seen_adj), 64'(0));
    chk("play_once", 64'(seen_play), 64'(0));
    @(negedge clk);
    chk("adj_valid_9", 64'(c_adjv), 64'(1));
    chk("adj_count", 64'(c_adj), 64'(adj_model(x, y)));
    chk("cursor_in_count", 64'({c_cy, c_cx}), cur_model());
    @(negedge clk);
    chk("adj_valid_once", 64'(c_adjv), 64'(0));
  endtask

  task automatic reveal_ignored(input string tag);
    press(6'b100000);
    chk(tag, 64'({c_play, c_bomb, c_win}), 64'(0));
    chk("rev_unchanged", c_rev, m_rev);
  endtask

  function automatic int pick(input bit want_mine);
    int idx;
    do idx = int'($urandom_range(0, 63));
    while (m_bombs[idx] != want_mine || m_rev[idx] || m_flag[idx]);
    return idx;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int idx, seen;
    use_b = 1'b0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    {btn_reveal, btn_flag, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_pulses_a", 64'({a_bomb, a_win, a_play, a_ready, a_adjv}), 64'(0));
    chk("rst_cursor_a", 64'({a_cy, a_cx}), 64'(0));
    chk("rst_maps_a", a_rev | a_flag | a_bmap, 64'(0));
    chk("rst_adj_a", 64'(a_adj), 64'(0));
    chk("rst_outs_b", 64'({b_bomb, b_win, b_play, b_ready, b_adjv, b_cy, b_cx, b_adj}), 64'(0));
    chk("rst_maps_b", b_rev | b_flag | b_bmap, 64'(0));
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(a_ready | a_play | a_bomb | a_win | a_adjv);
    end
    chk("idle_20", 64'(seen), 64'(0));

    // Game on the 10-mine board.
    repeat ($urandom_range(0, 40)) @(negedge clk);
    start_a = 1'b1;
    wait_ready(200, "ready_a");
    m_bombs = c_bmap;
    m_rev = '0;
    m_flag = '0;
    m_x = 0;
    m_y = 0;
    chk("popcount_10", 64'($countones(c_bmap)), 64'(10));
    chk("start_rev", c_rev, 64'(0));
    chk("start_cursor", 64'({c_cy, c_cx}), 64'(0));

    move(4'b1000);
    move(4'b0010);
    repeat (9) move(4'b0001);
    chk("cursor_x_sat", 64'(c_cx), 64'(7));
    repeat (40) move(4'($urandom_range(1, 15)));

    // Flag toggling and reveal of a flagged cell.
    idx = pick(1'b0);
    goto_cell(idx % 8, idx / 8);
    press(6'b010000);
    m_flag[idx] = 1'b1;
    chk("flag_set", c_flag, m_flag);
    chk("flag_no_play", 64'(c_play), 64'(0));
    reveal_ignored("flagged_reveal");
    press(6'b011000);
    m_flag[idx] = 1'b0;
    chk("flag_clear", c_flag, m_flag);
    chk("flag_beats_up", 64'({c_cy, c_cx}), cur_model());

    if (!m_bombs[0]) reveal_safe(0, 0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      idx = pick(1'b0);
      reveal_safe(idx % 8, idx / 8, 1'($urandom_range(0, 1)));
    end
    reveal_ignored("again_reveal");
    press(6'b010000);
    chk("flag_on_revealed", c_flag, m_flag);

    // Mine reveal ends the game.
    idx = pick(1'b1);
    goto_cell(idx % 8, idx / 8);
    exp_q.push_back(3'b110);
    press(6'b100000);
    m_rev = m_rev | m_bombs;
    chk("mine_pulses", 64'({c_play, c_bomb, c_win}), 64'(exp_q.pop_front()));
    chk("mine_rev", c_rev, m_rev);
    chk("done_not_ready", 64'(c_ready), 64'(0));
    @(negedge clk);
    chk("mine_once", 64'({c_play, c_bomb, c_win}), 64'(0));
    reveal_ignored("done_reveal");
    press(6'b000001);
    chk("done_no_move", 64'({c_cy, c_cx}), cur_model());
    start_a = 1'b0;
    @(negedge clk);
    chk("done_idle", 64'(c_ready), 64'(0));
    chk("maps_held", c_bmap, m_bombs);

    // Abort in the middle of a neighbour scan.
    start_a = 1'b1;
    wait_ready(200, "ready_a2");
    m_bombs = c_bmap;
    m_rev = '0;
    m_x = 0;
    m_y = 0;
    chk("restart_rev", c_rev, 64'(0));
    chk("restart_cursor", 64'({c_cy, c_cx}), 64'(0));
    chk("popcount_10b", 64'($countones(c_bmap)), 64'(10));
    idx = pick(1'b0);
    goto_cell(idx % 8, idx / 8);
    press(6'b100000);
    m_rev[idx] = 1'b1;
    chk("abort_play", 64'({c_play, c_bomb, c_win}), 64'(3'b100));
    @(negedge clk);
    start_a = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(c_adjv | c_play | c_ready);
    end
    chk("abort_quiet", 64'(seen), 64'(0));
    chk("abort_maps_held", c_rev, m_rev);

    // 63-mine board: the single safe cell wins immediately.
    use_b = 1'b1;
    m_x = 0;
    m_y = 0;
    start_b = 1'b1;
    wait_ready(5000, "ready_b");
    m_bombs = c_bmap;
    m_rev = '0;
    m_flag = '0;
    chk("popcount_63", 64'($countones(c_bmap)), 64'(63));
    idx = pick(1'b0);
    goto_cell(idx % 8, idx / 8);
    exp_q.push_back(3'b101);
    press(6'b100000);
    chk("win_pulses", 64'({c_play, c_bomb, c_win}), 64'(exp_q.pop_front()));
    chk("win_not_ready", 64'(c_ready), 64'(0));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(c_adjv | c_play | c_win);
    end
    chk("win_no_adj", 64'(seen), 64'(0));
    start_b = 1'b0;
    @(negedge clk);
    start_b = 1'b1;
    m_x = 0;
    m_y = 0;
    wait_ready(5000, "ready_b2");
    chk("restart_b_rev", c_rev, 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tablero_buscaminas.md
Name: tablero_buscaminas

Overview:
Board controller for the minesweeper game. It is the stage directly upstream of the game FSM: it consumes that FSM's start_game level and produces the bomb, win and play pulses the FSM acts on. It owns an 8x8 board (cell index = y*8+x), places mines pseudo-randomly, moves a cursor, reveals and flags cells, and counts the mines adjacent to each revealed cell for display.

Parameters:
BOMBS, 10, number of mines placed per game; legal range 1..63.
LFSR_SEED, 16'hACE1, reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start_game  in  1  level from game FSM; high = game in progress
btn_up  in  1  single-cycle pulse (debounced upstream); same for next four
btn_down  in  1  move cursor y+1
btn_left  in  1  move cursor x-1
btn_right  in  1  move cursor x+1
btn_reveal  in  1  reveal cell under cursor
btn_flag  in  1  toggle flag on cell under cursor
bomb  out  1  one-cycle pulse: a mine was revealed
win  out  1  one-cycle pulse: last safe cell revealed
play  out  1  one-cycle pulse: a reveal was accepted
ready  out  1  high while in PLAY (board placed, accepting input)
cursor_x  out  3  cursor column
cursor_y  out  3  cursor row
revealed_map  out  64  bit i = cell i revealed
flag_map  out  64  bit i = cell i flagged
bomb_map  out  64  bit i = cell i holds a mine
adj_count  out  4  mines adjacent to last revealed safe cell (0..8)
adj_valid  out  1  one-cycle pulse when adj_count updates

Behaviour:
- Reset: state IDLE; all outputs 0; cursor (0,0); LFSR = LFSR_SEED; counters 0.
- LFSR advances every cycle in every state, including IDLE, so the time spent in IDLE randomises placement.
- States: IDLE, PLACE, PLAY, COUNT, DONE.
- IDLE: wait for start_game==1.
  - Then clear all maps, adj_count, the placed counter and the safe counter; set cursor to (0,0); go to PLACE.
- PLACE: each cycle, idx = lfsr[5:0].
  - If bomb_map[idx]==0, set the bit and increment placed.
  - When placed reaches BOMBS, go to PLAY on the next edge.
  - Duplicate indices are skipped, so duration is variable but is at least BOMBS cycles.
- PLAY, priority per cycle: reveal > flag > moves.
  - Only one action per cycle; lower-priority inputs that cycle are dropped.
- Moves: priority up > down > left > right.
  - Coordinates saturate at 0 and 7 (no wrap).
- Reveal: applies to the current cursor cell.
  - If the cell is revealed or flagged, the reveal is ignored: no play, no state change.
  - Otherwise set the revealed bit; play=1 on the following cycle.
  - Mine: bomb=1 on the same cycle as play; revealed_map |= bomb_map; go to DONE.
  - Safe, and safe count +1 == 64-BOMBS: win=1 on the same cycle as play; go to DONE, no COUNT.
  - Otherwise: increment safe count; go to COUNT.
- Flag: toggles the flag bit of an unrevealed cell; ignored on a revealed cell; no play pulse.
- COUNT: scans the 8 neighbours of the revealed cell, one per cycle, in the order NW, N, NE, W, E, SW, S, SE.
  - Off-board neighbours contribute 0.
  - After 8 scan cycles, update adj_count and pulse adj_valid; return to PLAY.
  - All buttons are ignored during COUNT.
  - Timing: adj_valid is asserted 9 cycles after the reveal edge.
- DONE: all buttons ignored; maps held for display. Go to IDLE when start_game==0.
- start_game falls during PLACE, PLAY or COUNT: abort to IDLE next edge with no pulses. Maps are held until the next start.
- bomb, win, play and adj_valid are never high for more than one cycle. bomb and win are never both high.
- rst asserted in any state: reset values on the next edge.

Test Plan:
- Reset hold 2 cycles, start_game=0 -> all outputs 0; cursor (0,0); state stays IDLE for 20 cycles.
- start_game=1, BOMBS=10 -> ready rises within 200 cycles; popcount(bomb_map)=10; revealed_map=0.
- In PLAY, btn_up and btn_left pulsed at (0,0) -> cursor stays (0,0). 9x btn_right -> cursor_x=7.
- Reveal a cell whose bomb_map bit is 1 (read from port) -> next cycle play=1 and bomb=1, win=0; revealed_map ⊇ bomb_map; further btn_reveal gives no play.
- Reveal a safe corner cell (0,0) whose three neighbours are all mines -> play=1 only; adj_valid 9 cycles after the reveal with adj_count=3. The same cell revealed again gives no play. A flagged cell on reveal gives no play.
- BOMBS=63 override, reveal the single safe cell -> play=1 and win=1 in the same cycle, no adj_valid. Drop start_game -> IDLE next edge.
